// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_arb_pkg : SDRAM port widths and arbiter state encoding   | rev 1.0
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int SD_ADDR_W = 25;
  localparam int SD_WORD_W = 16;
  localparam int SD_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_RESYNC   = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker : first requester at or after the pointer, wrapping   | rev 1.0
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_CLIENTS = 3
) (
  input  logic [NUM_CLIENTS-1:0]         req,
  input  logic [$clog2(NUM_CLIENTS)-1:0] ptr,
  output logic                           valid,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CLIENTS);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_client_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_client_arbiter : round-robin share of one SDRAM controller port | rev 1.0
// ---------------------------------------------------------------------------
module sdram_client_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = SD_ADDR_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           cl_req,
  input  logic [NUM_CLIENTS-1:0]           cl_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]    cl_addr,
  input  logic [NUM_CLIENTS*SD_WORD_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]           cl_ack,
  output logic [SD_BYTE_W-1:0]             cl_rdata,
  output logic [ADDR_W-1:0]                sd_raddr,
  output logic                             sd_rd,
  input  logic                             sd_rd_rdy,
  input  logic [SD_BYTE_W-1:0]             sd_dout,
  output logic [ADDR_W-1:0]                sd_waddr,
  output logic [SD_WORD_W-1:0]             sd_din,
  output logic                             sd_we,
  output logic                             sd_we_req,
  input  logic                             sd_we_ack
);

  localparam int               IDX_W    = $clog2(NUM_CLIENTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

  logic [ADDR_W-1:0]    addr_arr  [NUM_CLIENTS];
  logic [SD_WORD_W-1:0] wdata_arr [NUM_CLIENTS];

  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = cl_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = cl_wdata[gi*SD_WORD_W +: SD_WORD_W];
    end
  endgenerate

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [NUM_CLIENTS-1:0] cl_ack_q, cl_ack_d;
  logic [SD_BYTE_W-1:0]   cl_rdata_q, cl_rdata_d;
  logic                   sd_rd_q, sd_rd_d;
  logic [ADDR_W-1:0]      sd_raddr_q, sd_raddr_d;
  logic [ADDR_W-1:0]      sd_waddr_q, sd_waddr_d;
  logic [SD_WORD_W-1:0]   sd_din_q, sd_din_d;
  logic                   sd_we_req_q, sd_we_req_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_picker (
    .req   (cl_req),
    .ptr   (rr_q),
    .valid (pick_valid),
    .grant (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    cl_ack_d    = '0;
    cl_rdata_d  = cl_rdata_q;
    sd_rd_d     = sd_rd_q;
    sd_raddr_d  = sd_raddr_q;
    sd_waddr_d  = sd_waddr_q;
    sd_din_d    = sd_din_q;
    sd_we_req_d = sd_we_req_q;

    case (state_q)
      ST_RESYNC: begin
        // The controller keeps its toggle across our reset; adopt its phase.
        sd_we_req_d = sd_we_ack;
        state_d     = ST_IDLE;
      end
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          if (cl_wr[pick_idx]) begin
            sd_waddr_d  = addr_arr[pick_idx];
            sd_din_d    = wdata_arr[pick_idx];
            sd_we_req_d = ~sd_we_req_q;
            state_d     = ST_WR_WAIT;
          end else begin
            sd_raddr_d = addr_arr[pick_idx];
            sd_rd_d    = 1'b1;
            state_d    = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        // rd_rdy falling means the controller took the read; drop rd before its next slot.
        if (!sd_rd_rdy) begin
          sd_rd_d = 1'b0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (sd_rd_rdy) begin
          cl_rdata_d        = sd_dout;
          cl_ack_d[grant_q] = 1'b1;
          state_d           = ST_DONE;
        end
      end
      ST_WR_WAIT: begin
        if (sd_we_ack == sd_we_req_q) begin
          cl_ack_d[grant_q] = 1'b1;
          state_d           = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_d    = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESYNC;
      rr_q        <= '0;
      grant_q     <= '0;
      cl_ack_q    <= '0;
      cl_rdata_q  <= '0;
      sd_rd_q     <= 1'b0;
      sd_raddr_q  <= '0;
      sd_waddr_q  <= '0;
      sd_din_q    <= '0;
      sd_we_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      cl_ack_q    <= cl_ack_d;
      cl_rdata_q  <= cl_rdata_d;
      sd_rd_q     <= sd_rd_d;
      sd_raddr_q  <= sd_raddr_d;
      sd_waddr_q  <= sd_waddr_d;
      sd_din_q    <= sd_din_d;
      sd_we_req_q <= sd_we_req_d;
    end
  end

  assign cl_ack    = cl_ack_q;
  assign cl_rdata  = cl_rdata_q;
  assign sd_rd     = sd_rd_q;
  assign sd_raddr  = sd_raddr_q;
  assign sd_waddr  = sd_waddr_q;
  assign sd_din    = sd_din_q;
  assign sd_we     = 1'b0;
  assign sd_we_req = sd_we_req_q;

endmodule
`default_nettype wire
